// File: rtl/ci_pkg.sv
// ci_pkg: shared CI master types, tilt codes and default widths
package ci_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RES_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, OUT = 2'd3} state_t;
  localparam logic [1:0] TILT_FLAT = 2'd0;
  localparam logic [1:0] TILT_LEFT = 2'd1;
  localparam logic [1:0] TILT_RIGHT = 2'd2;
  localparam logic [1:0] TILT_FWD = 2'd3;
endpackage

// File: rtl/ci_timeout_ctr.sv
// ci_timeout_ctr: loadable down-counter with zero flag for bounding CI slave waits
module ci_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  assign zero = count == '0;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (dec && !zero) count <= count - 1'b1;
endmodule

// File: rtl/ci_tilt_master.sv
// ci_tilt_master: autonomous CI initiator feeding sample pairs to the tilt unit; TILT_CHANGE_ONLY_EN suppresses repeated codes
module ci_tilt_master import ci_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RES_W = DEF_RES_W,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_x,
  input  logic [DATA_W-1:0] s_y,
  input  logic              s_mode,
  output logic              ci_clk_en,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  output logic [DATA_W-1:0] ci_datab,
  output logic              ci_datac,
  input  logic [RES_W-1:0]  ci_result,
  input  logic              ci_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [RES_W-1:0]  m_tilt,
  output logic              m_timeout,
  output logic              busy
);
  state_t state, state_n;
  logic zero, in_ci, accept, capture, tmo, same;
  assign in_ci = state == ISSUE || state == WAIT;
  assign accept = state == IDLE && s_valid;
  assign capture = in_ci && ci_done;
  assign tmo = state == WAIT && !ci_done && zero;
  assign s_ready = state == IDLE && !reset;
`ifdef TILT_CHANGE_ONLY_EN
  logic [RES_W-1:0] last_tilt;
  assign same = ci_result == last_tilt;
  always_ff @(posedge clk)
    if (reset) last_tilt <= '0;
    else if (capture && !same) last_tilt <= ci_result;
`else
  assign same = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = s_valid ? ISSUE : IDLE;
      ISSUE, WAIT: state_n = capture ? (same ? IDLE : OUT) : (tmo ? OUT : WAIT);
      OUT: state_n = m_ready ? IDLE : OUT;
    endcase
  end
  ci_timeout_ctr #(.W(8)) u_ctr (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .dec(in_ci),
    .load_val(8'(TIMEOUT)),
    .zero(zero)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      ci_clk_en <= 1'b0;
      ci_start <= 1'b0;
      busy <= 1'b0;
      m_valid <= 1'b0;
      m_tilt <= '0;
      m_timeout <= 1'b0;
      ci_dataa <= '0;
      ci_datab <= '0;
      ci_datac <= 1'b0;
    end else begin
      state <= state_n;
      ci_clk_en <= state_n == ISSUE || state_n == WAIT;
      ci_start <= state_n == ISSUE;
      busy <= state_n != IDLE;
      m_valid <= state_n == OUT;
      if (accept) begin
        ci_dataa <= s_x;
        ci_datab <= s_y;
        ci_datac <= s_mode;
      end
      if (capture) begin
        m_tilt <= ci_result;
        m_timeout <= 1'b0;
      end else if (tmo) begin
        m_tilt <= '0;
        m_timeout <= 1'b1;
      end
    end
endmodule

// File: doc/ci_tilt_master.md
Name: ci_tilt_master

Overview:
- Initiator side of the Nios-style custom-instruction (CI) handshake: drives clk_en/start/dataa/datab/datac into a multi-cycle CI slave (e.g. the tilt unit) and captures result on done.
- Accepts accelerometer sample pairs from the sampling logic over valid/ready.
- Returns the 2-bit tilt code over valid/ready.
- Lets the tilt unit run autonomously, without a CPU issuing the custom instruction.

Parameters:
- DATA_W, 32, width of dataa/datab operands
- RES_W, 2, width of CI result
- TIMEOUT, 31, max cycles waited for done after start; range 1..255; 0 is illegal

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- s_valid  in  1  sample pair valid
- s_ready  out  1  block can accept a sample (IDLE only)
- s_x  in  DATA_W  x-axis sample -> dataa
- s_y  in  DATA_W  y-axis sample -> datab
- s_mode  in  1  mode bit -> datac
- ci_clk_en  out  1  CI clock enable
- ci_start  out  1  CI start pulse
- ci_dataa  out  DATA_W  CI operand a
- ci_datab  out  DATA_W  CI operand b
- ci_datac  out  1  CI operand c
- ci_result  in  RES_W  CI result
- ci_done  in  1  CI done, single-cycle
- m_valid  out  1  tilt result valid
- m_ready  in  1  downstream accepts result
- m_tilt  out  RES_W  captured tilt code
- m_timeout  out  1  qualifies m_valid: transaction timed out, m_tilt forced to 0
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports named clk and reset.
- Reset values: s_ready=0 during reset, 1 the cycle after; all other outputs 0; state=IDLE; timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - s_ready=1.
  - On s_valid: register s_x/s_y/s_mode into operand regs; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ci_start=1, ci_clk_en=1; operands driven from regs; counter loaded with TIMEOUT.
  - If ci_done=1 in this cycle (zero-latency slave): capture ci_result, go to OUT.
  - Otherwise go to WAIT.
- WAIT:
  - ci_clk_en=1, ci_start=0, operands held stable; counter decrements each cycle.
  - ci_done=1: capture ci_result into m_tilt, m_timeout=0, go to OUT.
  - Counter reaches 0 without done: m_tilt=0, m_timeout=1, go to OUT.
  - ci_done on the same cycle the counter hits 0: done wins (valid result).
- OUT:
  - m_valid=1; m_tilt/m_timeout held stable until m_ready.
  - ci_clk_en=0; the slave then clears its internal timer.
  - On m_valid & m_ready: go to IDLE; s_ready rises the next cycle (no same-cycle re-accept).
- Interface invariants:
  - ci_clk_en is 1 only in ISSUE/WAIT; ci_start is 1 only in ISSUE.
  - ci_dataa/datab/datac change only on IDLE acceptance.
- Throughput: one transaction per (slave latency + 3) cycles minimum.
- Stray ci_done outside ISSUE/WAIT: ignored.
- Reset mid-transaction: immediately IDLE, all outputs to reset values, pending result discarded; ci_clk_en dropping also resets the slave.
- All outputs registered except s_ready (decoded from state).

Optional Feature:
- Macro: TILT_CHANGE_ONLY_EN.
- Defined:
  - Adds last_tilt register (reset 0).
  - A non-timeout result equal to last_tilt skips OUT and returns to IDLE directly.
  - A differing result updates last_tilt and goes to OUT.
  - Timeouts always go to OUT and never update last_tilt.
- Undefined: every transaction produces one OUT beat.

Decomposition:
- Package ci_pkg:
  - State enum (IDLE, ISSUE, WAIT, OUT).
  - Tilt code constants: TILT_FLAT=2'd0, TILT_LEFT=2'd1, TILT_RIGHT=2'd2, TILT_FWD=2'd3.
  - Default DATA_W/RES_W.
- Sub-module ci_timeout_ctr: loadable down-counter with zero flag, also reusable by other CI masters.
- FSM and datapath stay in ci_tilt_master.

Test Plan:
- Latency-3 slave model; s_x=32'h0000_0100, s_y=32'h0000_0000; done 3 cycles after start with result=2'd1 -> m_valid with m_tilt=1, m_timeout=0; ci_clk_en high for exactly 4 cycles; start high for 1 cycle.
- Zero-latency slave (done in start cycle, result=2'd2) -> OUT the next cycle, m_tilt=2, no WAIT cycle.
- Slave never asserts done, TIMEOUT=31 -> m_valid exactly 32 cycles after ISSUE, m_timeout=1, m_tilt=0; ci_clk_en then 0.
- m_ready held low 10 cycles in OUT -> m_tilt stable, s_ready=0 throughout, second s_valid not accepted until the cycle after handshake.
- reset asserted in WAIT cycle 2 -> next cycle state IDLE, ci_clk_en=0, m_valid=0; a late ci_done is ignored.
- With TILT_CHANGE_ONLY_EN, results 1,1,3 -> exactly two m_valid beats (1,3); without the macro -> three beats.
